fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Write side of the Toeplitz input FIFO; the read side of total_module drains the same FIFO.
//  Collects a serial key bitstream (valid/ready) into WORD_W-bit words.
//  Pushes each word into the FIFO with a one-word hold buffer, and respects fifo_full backpressure.
//  A frame-last marker zero-pads and flushes the final partial word, then pulses frame_done.
// PARAMETERS
//  WORD_W     32  FIFO word width in bits (>=2)
//  CNT_W      16  width of the words_written counter
//  MSB_FIRST  1   1: first bit of a word lands in bit WORD_W-1; 0: first bit lands in bit 0
// PORTS
//  clk_in         in   1       single clock; all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  bit_in         in   1       serial data bit
//  bit_valid      in   1       bit_in is valid this cycle
//  bit_last       in   1       qualifies bit_valid: last bit of the frame
//  bit_ready      out  1       packer accepts bit_in this cycle (transfer = valid & ready)
//  fifo_full      in   1       FIFO full flag, driven by the FIFO (registered there)
//  fifo_wr_en     out  1       FIFO write strobe, one word per high cycle
//  fifo_din       out  WORD_W  FIFO write data
//  frame_done     out  1       1-cycle pulse when the frame's final word is written
//  words_written  out  CNT_W   words pushed since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - clears accumulator, bit count, hold_valid, state=FILL, words_written=0, frame_done=0.
//   - fifo_wr_en is gated by ~rst, so it is 0 during any reset cycle.
//   - Partial or held words are discarded.
//  State
//   - bit count cnt runs 0..WORD_W-1.
//   - hold register: hold_data, hold_valid, hold_last.
//   - FSM states: FILL, DRAIN.
//  Write side (combinational from registers)
//   - fifo_wr_en = hold_valid & ~fifo_full & ~rst.
//   - fifo_din = hold_data.
//   - A write clears hold_valid at the edge unless a new word is loaded the same cycle.
//  Word completion (in FILL)
//   - Triggered by a transfer with cnt==WORD_W-1, or by any transfer with bit_last=1.
//   - Completed word loads into hold the next edge.
//   - Latency: completing bit accepted at cycle t -> fifo_wr_en at t+1 if not full.
//   - cnt returns to 0 and the accumulator clears.
//  Bit packing
//   - MSB_FIRST=1: shift left, bit i of the word at position WORD_W-1-i.
//     A partial word of k bits is left-aligned, low WORD_W-k bits are 0.
//   - MSB_FIRST=0: bit i at position i; unused upper bits are 0.
//  bit_ready
//   - In FILL: bit_ready = ~(hold_valid & fifo_full) when the bit would complete a word
//     (cnt==WORD_W-1 or bit_last); otherwise 1.
//   - When hold is written in the same cycle, the new word replaces it (no bubble).
//   - bit_ready=0 in DRAIN and during rst.
//  Frame end
//   - A word completed with bit_last sets hold_last=1 and moves FSM FILL->DRAIN.
//   - In DRAIN, the write of the hold_last word raises frame_done the next cycle for 1 cycle,
//     and FSM returns to FILL.
//   - bit_last on the WORD_W-th bit produces no extra pad word.
//  Counter
//   - words_written increments by 1 on every fifo_wr_en cycle; wraps modulo 2^CNT_W.
//  Protocol rules
//   - bit_in, bit_last are ignored when bit_valid=0.
//   - fifo_full may toggle any cycle; words are never dropped or reordered.
// TESTING
//  T1: 32 bits of 0xA5A5A5A5 MSB-first, fifo_full=0 -> single fifo_wr_en with fifo_din=0xA5A5A5A5,
//      1 cycle after the 32nd bit; words_written=1.
//  T2: fifo_full=1, stream 64 bits (0x11111111, 0x22222222) -> bit_ready=0 at the 64th bit, no writes;
//      drop fifo_full -> writes 0x11111111 then 0x22222222 on consecutive cycles.
//  T3: bits 1,0,1,1,0 with bit_last on the 5th -> fifo_din=0xB0000000 written, then frame_done pulse;
//      with MSB_FIRST=0 -> fifo_din=0x0000000D.
//  T4: 32 bits with bit_last on the 32nd -> exactly one write and one frame_done; the next frame starts cleanly.
//  T5: rst for 1 cycle after 17 bits, and again with a word held under fifo_full=1 -> no write;
//      words_written=0; the next 32 bits give an exact word.
//  T6: CNT_W=4, push 17 words with random fifo_full -> words_written=1;
//      all 17 words match a reference model in order.

Source files
------------

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Write side of the Toeplitz input FIFO. Collects a serial key bitstream
//   (valid/ready) into WORD_W-bit words. Each word goes through a one-word
//   hold buffer into the FIFO, and the FIFO's full flag applies backpressure.
//   A frame-last bit zero-pads and flushes the final partial word. A one-cycle
//   frame_done pulse follows the write of that word.
// Ports
//   clk_in        : single clock, rising edge
//   rst           : synchronous reset, active-high
//   bit_in        : serial data bit
//   bit_valid     : bit_in valid this cycle
//   bit_last      : with bit_valid, marks the last bit of the frame
//   bit_ready     : packer accepts bit_in this cycle
//   fifo_full     : FIFO full flag
//   fifo_wr_en    : FIFO write strobe, one word per high cycle
//   fifo_din      : FIFO write data
//   frame_done    : 1-cycle pulse after the frame's final word is written
//   words_written : words pushed since reset, wraps modulo 2^CNT_W
module fifo_word_packer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              bit_last,
  output logic              bit_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic              frame_done,
  output logic [CNT_W-1:0]  words_written
);

  localparam int unsigned    CW       = $clog2(WORD_W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WORD_W - 1);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic              hold_last_q, hold_last_d;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  words_written_q, words_written_d;
  logic              frame_done_q, frame_done_d;

  logic              would_complete;
  logic              xfer;
  logic [WORD_W-1:0] acc_next;
  logic [WORD_W-1:0] word;

  always_comb begin
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    hold_data_d     = hold_data_q;
    hold_valid_d    = hold_valid_q;
    hold_last_d     = hold_last_q;
    state_d         = state_q;
    words_written_d = words_written_q;
    frame_done_d    = 1'b0;
    acc_next        = '0;
    word            = '0;

    would_complete = (cnt_q == CNT_LAST) | (bit_valid & bit_last);
    // A completing bit may only enter when the hold slot is free or is
    // being written this same cycle.
    bit_ready  = ~rst & (state_q == FILL) & ~(would_complete & hold_valid_q & fifo_full);
    fifo_wr_en = hold_valid_q & ~fifo_full & ~rst;
    xfer       = bit_valid & bit_ready;

    if (MSB_FIRST) begin
      acc_next = {acc_q[WORD_W-2:0], bit_in};
      // Left-align a partial word. The low bits are already zero.
      word     = acc_next << (CNT_LAST - cnt_q);
    end else begin
      acc_next = acc_q | ({{(WORD_W-1){1'b0}}, bit_in} << cnt_q);
      word     = acc_next;
    end

    if (fifo_wr_en) begin
      hold_valid_d    = 1'b0;
      hold_last_d     = 1'b0;
      words_written_d = words_written_q + CNT_W'(1);
      if (hold_last_q) begin
        frame_done_d = 1'b1;
        state_d      = FILL;
      end
    end

    // A load here overrides the write-clear above, so the hold slot refills without a bubble.
    if (xfer) begin
      if (would_complete) begin
        hold_data_d  = word;
        hold_valid_d = 1'b1;
        hold_last_d  = bit_last;
        acc_d        = '0;
        cnt_d        = '0;
        if (bit_last) state_d = DRAIN;
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc_q           <= '0;
      cnt_q           <= '0;
      hold_data_q     <= '0;
      hold_valid_q    <= 1'b0;
      hold_last_q     <= 1'b0;
      state_q         <= FILL;
      words_written_q <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      hold_data_q     <= hold_data_d;
      hold_valid_q    <= hold_valid_d;
      hold_last_q     <= hold_last_d;
      state_q         <= state_d;
      words_written_q <= words_written_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign fifo_din      = hold_data_q;
  assign frame_done    = frame_done_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Drives two packers with the same stimulus: one MSB-first with a 16-bit
//   counter, one LSB-first with a 4-bit counter. A queue-based reference
//   model predicts ready, writes, data, frame_done and the counters each cycle.
module tb_fifo_word_packer;

  localparam int unsigned W = 32;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_last = 1'b0;
  logic fifo_full = 1'b0;

  logic        ready_a, wr_a, fd_a;
  logic [31:0] din_a;
  logic [15:0] ww_a;
  logic        ready_b, wr_b, fd_b;
  logic [31:0] din_b;
  logic [3:0]  ww_b;

  fifo_word_packer #(.WORD_W(32), .CNT_W(16), .MSB_FIRST(1'b1)) dut_a (
    .clk_in(clk_in), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_last(bit_last), .bit_ready(ready_a), .fifo_full(fifo_full),
    .fifo_wr_en(wr_a), .fifo_din(din_a), .frame_done(fd_a), .words_written(ww_a)
  );

  fifo_word_packer #(.WORD_W(32), .CNT_W(4), .MSB_FIRST(1'b0)) dut_b (
    .clk_in(clk_in), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_last(bit_last), .bit_ready(ready_b), .fifo_full(fifo_full),
    .fifo_wr_en(wr_b), .fifo_din(din_b), .frame_done(fd_b), .words_written(ww_b)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [31:0] msb;
    logic [31:0] lsb;
    logic        last;
  } word_t;

  word_t       pend[$];       // completed words not yet written
  logic        cur[$];        // bits of the word being collected
  logic        drain = 1'b0;  // frame-last word awaiting write
  logic        exp_fd = 1'b0;
  int unsigned exp_count = 0;
  logic        xfer_seen = 1'b0;

  logic rand_full = 1'b0;
  logic full_force = 1'b0;

  task automatic monitor();
    logic would_complete, exp_ready, exp_wr;
    word_t w;
    forever begin
      @(negedge clk_in);
      would_complete = (cur.size() == W - 1) || (bit_valid && bit_last);
      exp_ready = !rst && !drain && !(would_complete && pend.size() != 0 && fifo_full);
      exp_wr    = !rst && pend.size() != 0 && !fifo_full;

      check("ready_a", 32'(ready_a), 32'(exp_ready));
      check("ready_b", 32'(ready_b), 32'(exp_ready));
      check("wr_en_a", 32'(wr_a), 32'(exp_wr));
      check("wr_en_b", 32'(wr_b), 32'(exp_wr));
      check("frame_done_a", 32'(fd_a), 32'(exp_fd));
      check("frame_done_b", 32'(fd_b), 32'(exp_fd));
      check("words_written_a", 32'(ww_a), exp_count % 65536);
      check("words_written_b", 32'(ww_b), exp_count % 16);
      if (exp_wr) begin
        check("din_msb_first", din_a, pend[0].msb);
        check("din_lsb_first", din_b, pend[0].lsb);
      end

      xfer_seen = bit_valid && exp_ready;

      if (rst) begin
        pend.delete();
        cur.delete();
        drain = 1'b0;
        exp_fd = 1'b0;
        exp_count = 0;
      end else begin
        exp_fd = exp_wr && pend[0].last;
        if (exp_wr) begin
          exp_count++;
          if (pend[0].last) drain = 1'b0;
          void'(pend.pop_front());
        end
        if (xfer_seen) begin
          cur.push_back(bit_in);
          if (cur.size() == W || bit_last) begin
            w.msb = '0;
            w.lsb = '0;
            for (int i = 0; i < cur.size(); i++) begin
              if (cur[i]) begin
                w.msb = w.msb | (32'd1 << (W - 1 - i));
                w.lsb = w.lsb | (32'd1 << i);
              end
            end
            w.last = bit_last;
            pend.push_back(w);
            if (bit_last) drain = 1'b1;
            cur.delete();
          end
        end
      end
    end
  endtask

  task automatic full_driver();
    forever begin
      @(posedge clk_in);
      #2;
      fifo_full = rand_full ? 1'($urandom_range(0, 1)) : full_force;
    end
  endtask

  // Offer one bit and hold it until it transfers (bounded).
  task automatic send_bit(input logic b, input logic last);
    int unsigned n;
    n = 0;
    bit_valid = 1'b1;
    bit_in = b;
    bit_last = last;
    do begin
      @(posedge clk_in);
      n++;
    end while (!xfer_seen && n < 400);
    if (!xfer_seen) check("send_timeout", 32'd0, 32'd1);
    #1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    bit_last = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int unsigned nbits, input logic last_end);
    for (int unsigned i = 0; i < nbits; i++)
      send_bit(w[31 - i], last_end && (i == nbits - 1));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      full_driver();
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    idle(2);
    rst = 1'b0;
    @(negedge clk_in);
    check("reset_words_written", 32'(ww_a), 32'd0);
    idle(1);

    // T1: one full MSB-first word
    send_word(32'hA5A5A5A5, 32, 1'b0);
    idle(3);
    check("t1_words_written", 32'(ww_a), 32'd1);

    // T2: two words under fifo_full, then release
    full_force = 1'b1;
    idle(2);
    send_word(32'h11111111, 32, 1'b0);
    send_word(32'h22222222, 31, 1'b0);
    bit_valid = 1'b1;
    bit_in = 1'b0;
    bit_last = 1'b0;
    idle(3);
    @(negedge clk_in);
    check("t2_stall_ready", 32'(ready_a), 32'd0);
    check("t2_stall_no_write", 32'(wr_a), 32'd0);
    full_force = 1'b0;
    send_bit(1'b0, 1'b0);
    idle(4);
    check("t2_words_written", 32'(ww_a), 32'd3);

    // T3: short frame 1,0,1,1,0
    send_word(32'hB0000000, 5, 1'b1);
    idle(4);

    // T4: full-length frame ending on the 32nd bit, then a clean next frame
    send_word(32'hDEADBEEF, 32, 1'b1);
    idle(4);
    check("t4_words_written", 32'(ww_a), 32'd5);
    send_word(32'h0F0F0F0F, 32, 1'b0);
    idle(3);

    // T5: reset mid-word, then reset with a held word
    send_word(32'hFFFF8000, 17, 1'b0);
    pulse_rst();
    @(negedge clk_in);
    check("t5_rst_words_written", 32'(ww_a), 32'd0);
    full_force = 1'b1;
    idle(2);
    send_word(32'h12345678, 32, 1'b0);
    idle(3);
    pulse_rst();
    full_force = 1'b0;
    idle(5);
    check("t5_held_discarded", 32'(ww_a), 32'd0);
    send_word(32'h87654321, 32, 1'b0);
    idle(3);
    check("t5_words_written", 32'(ww_a), 32'd1);

    // T6: 17 random words under random backpressure, 4-bit counter wraps
    pulse_rst();
    rand_full = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send_word($urandom, 32, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_full = 1'b0;
    full_force = 1'b0;
    idle(6);
    check("t6_ww_wrap_b", 32'(ww_b), 32'd1);
    check("t6_ww_a", 32'(ww_a), 32'd17);

    // Random frames with occasional frame-last and gaps
    rand_full = 1'b1;
    for (int k = 0; k < 400; k++) begin
      send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
    end
    send_bit(1'b1, 1'b1);
    rand_full = 1'b0;
    full_force = 1'b0;
    idle(8);
    check("final_drained", 32'(wr_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
